// File: rtl/alu_pipelined.sv
// Pipelined ALU with valid/ready handshakes and a multi-cycle MATCH scan.
// Define ALU_SAT_EN to make ADD/SUB saturate in unsigned terms.
module alu_pipelined #(
  parameter int DATA_WIDTH = 64,
  parameter int PAT_WIDTH  = 8,
  parameter int STEP       = 8,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] alu_in1_i,
  input  logic [DATA_WIDTH-1:0] alu_in2_i,
  input  logic [3:0]            aluctrl_i,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] alu_o,
  output logic                  cout_o,
  output logic                  ovf_o,
  output logic                  alu_a_gt_b,
  output logic                  alu_a_lt_b,
  output logic                  zero,
  output logic                  match_o
);

  localparam int SW   = $clog2(DATA_WIDTH);
  localparam int KMAX = (DATA_WIDTH - PAT_WIDTH) / STEP;
  localparam int KW   = (KMAX > 0) ? $clog2(KMAX + 1) : 1;

  localparam logic [3:0] OP_AND   = 4'h0;
  localparam logic [3:0] OP_OR    = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_XOR   = 4'h3;
  localparam logic [3:0] OP_CMP   = 4'h4;
  localparam logic [3:0] OP_XNOR  = 4'h5;
  localparam logic [3:0] OP_SUB   = 4'h6;
  localparam logic [3:0] OP_LSL   = 4'h7;
  localparam logic [3:0] OP_LSR   = 4'h8;
  localparam logic [3:0] OP_ASR   = 4'h9;
  localparam logic [3:0] OP_MATCH = 4'hA;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic                  accept;
  logic [DATA_WIDTH:0]   add_w;
  logic [DATA_WIDTH:0]   sub_w;
  logic [SW-1:0]         sh;
  logic                  a_msb;
  logic                  b_msb;
  logic [DATA_WIDTH-1:0] r_res;
  logic                  r_c;
  logic                  r_v;
  logic                  r_gt;
  logic                  r_lt;
  logic                  r_z;

  logic [DATA_WIDTH-1:0] sd_q;
  logic [PAT_WIDTH-1:0]  pat_q;
  logic [KW-1:0]         k_q;
  logic [DATA_WIDTH-1:0] scan_d;
  logic [PAT_WIDTH-1:0]  scan_p;
  logic [KW-1:0]         k_cur;
  logic [SW-1:0]         off;
  logic [PAT_WIDTH-1:0]  win;
  logic                  hit;
  logic                  last;
  logic                  m_fire;
  logic [DATA_WIDTH-1:0] m_res;
  logic                  m_z;

  assign in_ready = !reset && (state == IDLE) &&
                    (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign sh       = alu_in2_i[SW-1:0];
  assign a_msb    = alu_in1_i[DATA_WIDTH-1];
  assign b_msb    = alu_in2_i[DATA_WIDTH-1];

  always_comb begin
    add_w = {1'b0, alu_in1_i} + {1'b0, alu_in2_i} +
            {{DATA_WIDTH{1'b0}}, cin};
    sub_w = {1'b0, alu_in1_i} + {1'b0, ~alu_in2_i} +
            {{DATA_WIDTH{1'b0}}, 1'b1};
    r_res = '0;
    r_c   = 1'b0;
    r_v   = 1'b0;
    r_gt  = 1'b0;
    r_lt  = 1'b0;
    case (aluctrl_i)
      OP_AND:  r_res = alu_in1_i & alu_in2_i;
      OP_OR:   r_res = alu_in1_i | alu_in2_i;
      OP_XOR:  r_res = alu_in1_i ^ alu_in2_i;
      OP_XNOR: r_res = ~(alu_in1_i ^ alu_in2_i);
      OP_ADD: begin
        r_res = add_w[DATA_WIDTH-1:0];
        r_c   = add_w[DATA_WIDTH];
        r_v   = (a_msb == b_msb) &&
                (add_w[DATA_WIDTH-1] != a_msb);
`ifdef ALU_SAT_EN
        if (add_w[DATA_WIDTH]) r_res = '1;
`endif
      end
      OP_SUB: begin
        r_res = sub_w[DATA_WIDTH-1:0];
        r_c   = sub_w[DATA_WIDTH];
        r_v   = (a_msb != b_msb) &&
                (sub_w[DATA_WIDTH-1] != a_msb);
`ifdef ALU_SAT_EN
        if (!sub_w[DATA_WIDTH]) r_res = '0;
`endif
      end
      OP_CMP: begin
        if (SIGNED_CMP) begin
          r_gt = $signed(alu_in1_i) > $signed(alu_in2_i);
          r_lt = $signed(alu_in1_i) < $signed(alu_in2_i);
        end else begin
          r_gt = alu_in1_i > alu_in2_i;
          r_lt = alu_in1_i < alu_in2_i;
        end
      end
      OP_LSL: r_res = alu_in1_i << sh;
      OP_LSR: r_res = alu_in1_i >> sh;
      OP_ASR: r_res = $signed(alu_in1_i) >>> sh;
      default: r_res = '0;
    endcase
    r_z = (aluctrl_i == OP_CMP) ? (alu_in1_i == alu_in2_i)
                                : (r_res == '0);
  end

  // Offset 0 is tested in the accept cycle, so a hit at k
  // lands its result at the end of cycle N+k.
  always_comb begin
    scan_d = (state == SCAN) ? sd_q : alu_in1_i;
    scan_p = (state == SCAN) ? pat_q : alu_in2_i[PAT_WIDTH-1:0];
    k_cur  = (state == SCAN) ? k_q : '0;
    off    = SW'(int'(k_cur) * STEP);
    win    = PAT_WIDTH'(scan_d >> off);
    hit    = (win == scan_p);
    last   = (k_cur == KW'(KMAX));
    m_res  = hit ? {{(DATA_WIDTH-SW){1'b0}}, off} : '0;
    m_z    = !hit || (k_cur == '0);
    m_fire = (hit || last) &&
             ((state == SCAN) ||
              (accept && aluctrl_i == OP_MATCH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      alu_o      <= '0;
      cout_o     <= 1'b0;
      ovf_o      <= 1'b0;
      alu_a_gt_b <= 1'b0;
      alu_a_lt_b <= 1'b0;
      zero       <= 1'b0;
      match_o    <= 1'b0;
      sd_q       <= '0;
      pat_q      <= '0;
      k_q        <= '0;
    end else if (m_fire) begin
      state      <= DONE;
      out_valid  <= 1'b1;
      alu_o      <= m_res;
      cout_o     <= 1'b0;
      ovf_o      <= 1'b0;
      alu_a_gt_b <= 1'b0;
      alu_a_lt_b <= 1'b0;
      zero       <= m_z;
      match_o    <= hit;
    end else begin
      case (state)
        IDLE: begin
          if (accept && aluctrl_i == OP_MATCH) begin
            state     <= SCAN;
            out_valid <= 1'b0;
            sd_q      <= alu_in1_i;
            pat_q     <= alu_in2_i[PAT_WIDTH-1:0];
            k_q       <= KW'(1);
          end else if (accept) begin
            out_valid  <= 1'b1;
            alu_o      <= r_res;
            cout_o     <= r_c;
            ovf_o      <= r_v;
            alu_a_gt_b <= r_gt;
            alu_a_lt_b <= r_lt;
            zero       <= r_z;
            match_o    <= 1'b0;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        SCAN: k_q <= k_q + 1'b1;
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipelined.sv
// Randomized bench for alu_pipelined against a behavioural model.
// Directed cases cover wrap, compare, MATCH latency, backpressure, reset.
module tb_alu_pipelined;

  localparam int DW   = 64;
  localparam bit SCMP = 1'b0;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] alu_in1_i = '0;
  logic [DW-1:0] alu_in2_i = '0;
  logic [3:0]    aluctrl_i = '0;
  logic          cin = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] alu_o;
  logic          cout_o;
  logic          ovf_o;
  logic          alu_a_gt_b;
  logic          alu_a_lt_b;
  logic          zero;
  logic          match_o;

  int checks = 0;
  int failures = 0;

  alu_pipelined #(
    .DATA_WIDTH(DW),
    .PAT_WIDTH (8),
    .STEP      (8),
    .SIGNED_CMP(SCMP)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_in1_i (alu_in1_i),
    .alu_in2_i (alu_in2_i),
    .aluctrl_i (aluctrl_i),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_o     (alu_o),
    .cout_o    (cout_o),
    .ovf_o     (ovf_o),
    .alu_a_gt_b(alu_a_gt_b),
    .alu_a_lt_b(alu_a_lt_b),
    .zero      (zero),
    .match_o   (match_o)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] flags();
    return {cout_o, ovf_o, alu_a_gt_b, alu_a_lt_b, zero, match_o};
  endfunction

  function automatic logic fits64(input logic signed [65:0] s);
    return (s[65:63] == 3'b000) || (s[65:63] == 3'b111);
  endfunction

  // Flags order: {cout, ovf, gt, lt, zero, match}
  function automatic void model(
    input  logic [3:0]  op,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        c,
    output logic [63:0] res,
    output logic [5:0]  fl,
    output int          lat
  );
    logic [64:0]        w;
    logic signed [65:0] s;
    logic               cy, v, gt, lt, z, m;
    int                 sh;
    res = '0; cy = 0; v = 0; gt = 0; lt = 0; m = 0;
    lat = 1;
    sh  = int'(b % 64);
    case (op)
      4'h0: res = a & b;
      4'h1: res = a | b;
      4'h3: res = a ^ b;
      4'h5: res = ~(a ^ b);
      4'h2: begin
        w   = {1'b0, a} + {1'b0, b} + 65'(c);
        res = w[63:0];
        cy  = w[64];
        s   = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b})
              + $signed({65'd0, c});
        v   = !fits64(s);
`ifdef ALU_SAT_EN
        if (cy) res = '1;
`endif
      end
      4'h6: begin
        res = a - b;
        cy  = (a >= b);
        s   = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
        v   = !fits64(s);
`ifdef ALU_SAT_EN
        if (!cy) res = '0;
`endif
      end
      4'h4: begin
        if (SCMP) begin
          gt = $signed(a) > $signed(b);
          lt = $signed(a) < $signed(b);
        end else begin
          gt = a > b;
          lt = a < b;
        end
      end
      4'h7: res = a << sh;
      4'h8: res = a >> sh;
      4'h9: res = $signed(a) >>> sh;
      4'hA: begin
        lat = 8;
        for (int k = 0; k <= 7; k++) begin
          if (!m && a[k*8 +: 8] == b[7:0]) begin
            m   = 1;
            res = 64'(k * 8);
            lat = k + 1;
          end
        end
      end
      default: res = '0;
    endcase
    z  = (op == 4'h4) ? (a == b) : (res == '0);
    fl = {cy, v, gt, lt, z, m};
  endfunction

  task automatic run_op(
    input  logic [3:0]  op,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        c,
    output logic [63:0] gr,
    output logic [5:0]  gf
  );
    logic [63:0] er;
    logic [5:0]  ef;
    int          el;
    int          n;
    model(op, a, b, c, er, ef, el);
    @(negedge clock);
    aluctrl_i = op; alu_in1_i = a; alu_in2_i = b; cin = c;
    in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("accept_wait", 64'(n < 50), 64'd1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk($sformatf("latency op%0d", op), 64'(n), 64'(el));
    chk($sformatf("result op%0d", op), alu_o, er);
    chk($sformatf("flags op%0d", op), 64'(flags()), 64'(ef));
    gr = alu_o;
    gf = flags();
  endtask

  logic [63:0] r;
  logic [5:0]  f;
  logic [3:0]  rop;
  logic [63:0] ra, rb;
  logic        seen;

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_alu_o", alu_o, 64'd0);
    chk("rst_flags", 64'(flags()), 64'd0);
    chk("rst_in_ready_after", 64'(in_ready), 64'd1);

    run_op(4'h2, '1, 64'd1, 1'b0, r, f);
`ifdef ALU_SAT_EN
    chk("add_sat_res", r, '1);
    chk("add_sat_zero", 64'(f[1]), 64'd0);
`else
    chk("add_wrap_res", r, 64'd0);
    chk("add_wrap_zero", 64'(f[1]), 64'd1);
`endif
    chk("add_cout", 64'(f[5]), 64'd1);

    run_op(4'h4, 64'd5, 64'd9, 1'b0, r, f);
    chk("cmp_lt", 64'(f[2]), 64'd1);
    chk("cmp_gt", 64'(f[3]), 64'd0);
    run_op(4'h4, '1, 64'd1, 1'b0, r, f);
    chk("cmp_unsigned_gt", 64'(f[3]), 64'd1);

    run_op(4'hA, 64'h0000_00AB_0000_0000, 64'hAB, 1'b0, r, f);
    chk("match_off", r, 64'd32);
    chk("match_hit", 64'(f[0]), 64'd1);
    run_op(4'hA, 64'h0000_00AB_0000_0000, 64'hCD, 1'b0, r, f);
    chk("match_miss", 64'(f[0]), 64'd0);
    chk("match_miss_zero", 64'(f[1]), 64'd1);

    run_op(4'h8, 64'hF0, 64'd68, 1'b0, r, f);
    chk("lsr_mod", r, 64'h0F);
    run_op(4'h9, 64'h8000_0000_0000_0000, 64'd4, 1'b0, r, f);
    chk("asr_fill", r, 64'hF800_0000_0000_0000);

    // Backpressure: second ADD waits while the first result stalls
    @(negedge clock);
    out_ready = 1'b0;
    aluctrl_i = 4'h2; alu_in1_i = 64'd10; alu_in2_i = 64'd20;
    cin = 1'b0; in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    alu_in1_i = 64'd100; alu_in2_i = 64'd5; cin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_hold", alu_o, 64'd30);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      @(negedge clock);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    chk("bp_second_valid", 64'(out_valid), 64'd1);
    chk("bp_second_res", alu_o, 64'd106);
    @(negedge clock);
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_hold", alu_o, 64'd106);

    // Reset in the middle of a scan
    @(negedge clock);
    aluctrl_i = 4'hA; alu_in1_i = 64'h0000_00AB_0000_0000;
    alu_in2_i = 64'hCD; in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
    end
    chk("no_stale", 64'(seen), 64'd0);

    for (int i = 0; i < 300; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) ra = '1;
      if ($urandom_range(0, 7) == 0) rb = 64'($urandom_range(0, 1));
      if (i % 5 == 0) rop = 4'hA;
      if (rop == 4'hA && $urandom_range(0, 2) != 0)
        rb[7:0] = 8'(ra >> (8 * $urandom_range(0, 7)));
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)), r, f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
